// File: rtl/nibble_adder_pkg.sv
// Package nibble_adder_pkg
// Shared definitions for the nibble-serial adder controller:
//   - NIB_W     : width of one adder slice (a nibble)
//   - state_t   : controller FSM encoding (ST_IDLE, ST_RUN, ST_DONE)
//   - idx_width : width of the nibble index counter for a given NIBBLES
package nibble_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // clog2 with a floor of one bit so NIBBLES=1 still yields a usable counter
  function automatic int idx_width(input int nibbles);
    if (nibbles <= 1) begin
      return 1;
    end else begin
      return $clog2(nibbles);
    end
  endfunction

endpackage

// File: rtl/nibble_adder_slice.sv
// Module nibble_adder_slice
// Purely combinational 4-bit ripple-carry adder; the single shared datapath
// resource of the serial adder.
// Ports:
//   a, b  in  NIB_W  nibble operands
//   cin   in  1      carry into bit 0
//   s     out NIB_W  nibble sum
//   cout  out 1      carry out of bit NIB_W-1
module nibble_adder_slice
  import nibble_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  logic [NIB_W:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ c_s[i];
    assign c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
  end

  assign cout = c_s[NIB_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Module nibble_serial_adder_ctrl
// Adds two NIBBLES*4-bit operands one nibble per clock (LSB first) through a
// single shared nibble_adder_slice, chaining the carry in a register.
// Optional feature macro: OVERFLOW_FLAG_EN adds the signed-overflow port ovf.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready    operand handshake (in_ready high only when idle)
//   a, b, cin            operands and carry into nibble 0
//   out_valid/out_ready  result handshake
//   sum, cout            registered result and carry out of the MSB nibble
//   busy                 high while computing or holding a result
//   ovf                  two's-complement overflow (OVERFLOW_FLAG_EN only)
module nibble_serial_adder_ctrl
  import nibble_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NIB_W*NIBBLES-1:0] a,
  input  logic [NIB_W*NIBBLES-1:0] b,
  input  logic                     cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NIB_W*NIBBLES-1:0] sum,
  output logic                     cout,
  output logic                     busy
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic                     ovf
`endif
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);

  state_t             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic               carry_r;
  logic [W-1:0]       a_r;
  logic [W-1:0]       b_r;

  logic [NIB_W-1:0]   a_nib_s;
  logic [NIB_W-1:0]   b_nib_s;
  logic [NIB_W-1:0]   nib_sum_s;
  logic               nib_cout_s;
  logic               last_s;

  // Nibble select: route the current nibble of each operand to the slice
  always_comb begin
    a_nib_s = a_r[idx_r*NIB_W +: NIB_W];
    b_nib_s = b_r[idx_r*NIB_W +: NIB_W];
    last_s  = (idx_r == IDX_W'(NIBBLES - 1));
  end

  nibble_adder_slice u_slice (
    .a    (a_nib_s),
    .b    (b_nib_s),
    .cin  (carry_r),
    .s    (nib_sum_s),
    .cout (nib_cout_s)
  );

`ifdef OVERFLOW_FLAG_EN
  // Carry into the top bit is recovered from that bit's sum and operands,
  // so the slice needs no extra port.
  logic ovf_s;
  assign ovf_s = (nib_sum_s[NIB_W-1] ^ a_nib_s[NIB_W-1] ^ b_nib_s[NIB_W-1]) ^ nib_cout_s;
`endif

  // Controller FSM with registered handshake flags, index, carry and result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      idx_r     <= '0;
      carry_r   <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            carry_r  <= cin;
            idx_r    <= '0;
            sum      <= '0;
`ifdef OVERFLOW_FLAG_EN
            ovf      <= 1'b0;
`endif
            state_r  <= ST_RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          sum[idx_r*NIB_W +: NIB_W] <= nib_sum_s;
          carry_r                   <= nib_cout_s;
          if (last_s) begin
            cout      <= nib_cout_s;
`ifdef OVERFLOW_FLAG_EN
            ovf       <= ovf_s;
`endif
            state_r   <= ST_DONE;
            out_valid <= 1'b1;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        ST_DONE: begin
          // Result stays in sum/cout after the handshake until the next accept
          if (out_ready) begin
            state_r   <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
